switch_port_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter for one switch output port.
- NUM_PORTS input-side requesters each present a byte stream framed by a data_status-style flag. The arbiter grants exactly one requester at a time for a whole packet and muxes its bytes onto the registered output port.
- Enforces a one-cycle inter-packet gap, downstream back-pressure and a maximum-packet-length watchdog.
- Sits between the input port buffers and each output port driver of the switch.

---
 rtl/switch_pkg.sv | 19 +
 rtl/switch_port_arbiter_rr_pick.sv | 39 +++
 rtl/switch_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_switch_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and default sizing for the switch output-port arbiter
//
// Purpose: arbiter state encoding, byte type and the default requester count /
// maximum packet length used by the arbiter, the input interface and the scoreboard.
package switch_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int MAX_LEN_DEF   = 64;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/switch_port_arbiter_rr_pick.sv
// rtl/switch_port_arbiter_rr_pick.sv - combinational round-robin selector
//
// Purpose: finds the first set request bit strictly after the last owner,
// wrapping around, so the last owner is the lowest priority.
// Ports:
//   req   - request vector, one bit per requester
//   last  - index of the previous owner
//   found - at least one request bit is set
//   idx   - selected requester (equals last when nothing is found)
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  // One extra bit so last+k (at most 2N-1) cannot overflow before wrapping.
  logic [IW:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/switch_port_arbiter.sv
// rtl/switch_port_arbiter.sv - packet-atomic round-robin arbiter for one switch output port
//
// Purpose: grants one requester at a time for a whole packet, forwards its bytes
// to a registered output, inserts an inter-packet gap, honours back-pressure and
// truncates packets longer than MAX_LEN.
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset
//   req_status     - per-requester frame flag (high first..last byte)
//   req_data       - per-requester current byte
//   req_ack        - per-requester byte consumed this cycle (combinational)
//   out_ready      - downstream accepts a byte this cycle
//   out_data       - registered output byte
//   out_valid      - out_data holds a new byte this cycle
//   out_status     - registered output frame flag
//   owner          - current / last granted requester
//   busy           - arbiter is not idle
//   err_trunc      - one-cycle pulse when a packet is cut at MAX_LEN
module switch_port_arbiter
  import switch_pkg::*;
#(
  parameter  int NUM_PORTS = NUM_PORTS_DEF,
  parameter  int MAX_LEN   = MAX_LEN_DEF,
  localparam int CNT_W     = $clog2(MAX_LEN + 1),
  localparam int IW        = $clog2(NUM_PORTS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_PORTS-1:0]      req_status,
  input  logic [NUM_PORTS-1:0][7:0] req_data,
  output logic [NUM_PORTS-1:0]      req_ack,
  input  logic                      out_ready,
  output byte_t                     out_data,
  output logic                      out_valid,
  output logic                      out_status,
  output logic [IW-1:0]             owner,
  output logic                      busy,
  output logic                      err_trunc
);

  arb_state_t       state, state_nx;
  logic [CNT_W-1:0] count;
  logic             found;
  logic [IW-1:0]    pick;
  logic             own_req;
  logic             at_max;

  rr_pick #(.N(NUM_PORTS)) u_rr_pick (
    .req   (req_status),
    .last  (owner),
    .found (found),
    .idx   (pick)
  );

  assign own_req = req_status[owner];
  // count reaches MAX_LEN only after the MAX_LEN-th byte was accepted; if the
  // requester is still framing at that point, the packet is too long.
  assign at_max  = (count == CNT_W'(MAX_LEN));
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    req_ack  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = XFER;
        end
      end
      XFER: begin
        if (!own_req) begin
          state_nx = GAP;
        end else if (at_max) begin
          state_nx = FLUSH;
        end else begin
          req_ack[owner] = out_ready;
        end
      end
      FLUSH: begin
        // Drain the oversize tail regardless of downstream back-pressure.
        req_ack[owner] = own_req;
        if (!own_req) begin
          state_nx = GAP;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= IW'(NUM_PORTS - 1);
      count      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_status <= 1'b0;
      err_trunc  <= 1'b0;
    end else begin
      err_trunc <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          out_status <= 1'b0;
          if (found) begin
            owner <= pick;
          end
        end
        XFER: begin
          if (!own_req) begin
            out_status <= 1'b0;
            count      <= '0;
          end else if (at_max) begin
            err_trunc  <= 1'b1;
            out_status <= 1'b0;
          end else if (out_ready) begin
            out_data   <= req_data[owner];
            out_valid  <= 1'b1;
            out_status <= 1'b1;
            count      <= count + CNT_W'(1);
          end
        end
        FLUSH: begin
          out_status <= 1'b0;
          if (!own_req) begin
            count <= '0;
          end
        end
        default: begin
          out_status <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_port_arbiter.sv
// tb/tb_switch_port_arbiter.sv - self-checking bench for switch_port_arbiter
module tb_switch_port_arbiter;
  import switch_pkg::*;

  localparam int N  = NUM_PORTS_DEF;
  localparam int ML = MAX_LEN_DEF;

  logic                 clock      = 1'b0;
  logic                 reset_n    = 1'b0;
  logic [N-1:0]         req_status = '0;
  logic [N-1:0][7:0]    req_data   = '0;
  logic [N-1:0]         req_ack;
  logic                 out_ready  = 1'b1;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_status;
  logic [$clog2(N)-1:0] owner;
  logic                 busy;
  logic                 err_trunc;

  always #5 clock = ~clock;

  switch_port_arbiter #(.NUM_PORTS(N), .MAX_LEN(ML)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_status (req_status),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_status (out_status),
    .owner      (owner),
    .busy       (busy),
    .err_trunc  (err_trunc)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state
  logic [7:0] src   [N][$];  // bytes each requester still has to present
  logic [7:0] exp_q [N][$];  // bytes each requester should see forwarded
  bit         was_empty [N];
  int         exp_trunc = 0;
  int         last_win  = N - 1;
  int         cur_win   = -1;
  int         grants[$];
  int         n_valid = 0, n_err = 0, n_frames = 0;
  int         run = 0, max_run = 0, low_run = 0;
  int         v0 = 0, e0 = 0, f0 = 0;
  bit         seen_frame = 0;
  logic       prev_status = 1'b0, prev_err = 1'b0;
  logic [7:0] last_data = 8'h00;

  logic [N-1:0] ack_q  = '0;
  logic [N-1:0] stat_q = '0;
  logic         arb_q  = 1'b0;

  always @(posedge clock) begin
    ack_q  <= req_ack;
    stat_q <= req_status;
    arb_q  <= reset_n && !busy && (|req_status);
  end

  function automatic int rr_model(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit any_src();
    for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_status[i] = (src[i].size() != 0);
      req_data[i]   = (src[i].size() != 0) ? src[i][0] : 8'h00;
    end
  endtask

  task automatic load(input int p, input int len, input logic [7:0] base, input bit rnd);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = rnd ? 8'($urandom) : 8'(base + k);
      src[p].push_back(b);
      if (k < ML) exp_q[p].push_back(b);
    end
    if (len > ML) exp_trunc++;
    drive();
  endtask

  task automatic mark();
    v0 = n_valid; e0 = n_err; f0 = n_frames; max_run = 0;
    grants.delete();
  endtask

  task automatic tick();
    int  w;
    bit  ok;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      was_empty[i] = (src[i].size() == 0);
      if (ack_q[i]) begin
        chk("ack_owner", i, cur_win);
        chk("ack_has_byte", src[i].size() != 0, 1);
        if (src[i].size() != 0) void'(src[i].pop_front());
      end
    end
    if (arb_q) begin
      w = rr_model(last_win, stat_q);
      chk("grant", owner, w);
      last_win = w;
      cur_win  = w;
      grants.push_back(w);
    end
    if (out_valid) begin
      n_valid++;
      run++;
      chk("valid_has_status", out_status, 1);
      ok = 1'b0;
      if (cur_win >= 0) ok = (exp_q[cur_win].size() != 0);
      chk("byte_expected", ok, 1);
      if (ok) chk("data", out_data, exp_q[cur_win].pop_front());
      last_data = out_data;
    end else begin
      run = 0;
      if (out_status) chk("hold", out_data, last_data);
    end
    if (run > max_run) max_run = run;
    if (err_trunc) begin
      n_err++;
      chk("trunc_single", prev_err, 0);
    end
    prev_err = err_trunc;
    if (out_status && !prev_status) begin
      n_frames++;
      if (seen_frame) chk("gap", low_run >= 2, 1);
      seen_frame = 1;
    end
    low_run     = out_status ? 0 : low_run + 1;
    prev_status = out_status;
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int c = 0;
    tick();
    while ((busy || any_src()) && c < budget) begin
      tick();
      c++;
    end
    chk("drain_timeout", c < budget, 1);
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_status", out_status, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, N - 1);
    for (int i = 0; i < N; i++) begin
      src[i].delete();
      exp_q[i].delete();
    end
    drive();
    @(negedge clock);
    reset_n     = 1'b1;
    last_win    = N - 1;
    cur_win     = -1;
    seen_frame  = 0;
    low_run     = 0;
    prev_status = 1'b0;
    prev_err    = 1'b0;
    last_data   = 8'h00;
  endtask

  initial begin
    int c;
    int exp_seq [4] = '{1, 3, 1, 3};
    int rdy_pat [5] = '{1, 0, 0, 1, 1};
    int len;

    drive();
    repeat (3) @(negedge clock);
    chk("init_valid", out_valid, 0);
    chk("init_status", out_status, 0);
    chk("init_data", out_data, 0);
    chk("init_err", err_trunc, 0);
    chk("init_owner", owner, N - 1);
    chk("init_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // Single 5-byte packet from requester 0
    mark();
    load(0, 5, 8'hA0, 0);
    #1;
    chk("idle_no_ack", req_ack, 0);
    tick();
    chk("first_ack", req_ack, 4'b0001);
    run_until_idle(200);
    chk("t1_valid", n_valid - v0, 5);
    chk("t1_consecutive", max_run, 5);
    chk("t1_owner", owner, 0);
    chk("t1_err", n_err - e0, 0);
    chk("t1_frames", n_frames - f0, 1);

    // Requesters 1 and 3 compete twice: expect 1,3,1,3
    mark();
    for (int r = 0; r < 2; r++) begin
      load(1, 4, 8'h10, 0);
      load(3, 3, 8'h30, 0);
      run_until_idle(200);
    end
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("rr_seq", grants[i], exp_seq[i]);
    end

    // Back-pressure pattern 1,0,0,1,1 on a 3-byte packet
    mark();
    load(2, 3, 8'h60, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy_pat[i][0];
      #1;
      chk("ack_follows_ready", req_ack[2], out_ready);
      tick();
    end
    out_ready = 1'b1;
    run_until_idle(200);
    chk("bp_valid", n_valid - v0, 3);
    chk("bp_frames", n_frames - f0, 1);

    // 70-byte packet truncated at 64, then a legal 64-byte packet
    mark();
    load(0, 70, 8'h00, 1);
    run_until_idle(500);
    chk("trunc_valid", n_valid - v0, ML);
    chk("trunc_err", n_err - e0, 1);
    chk("trunc_frames", n_frames - f0, 1);
    mark();
    load(1, ML, 8'h00, 1);
    run_until_idle(500);
    chk("max_valid", n_valid - v0, ML);
    chk("max_err", n_err - e0, 0);

    // Reset during byte 3 of a packet, then arbitration restarts at requester 0
    mark();
    load(1, 8, 8'h50, 0);
    c = 0;
    while (n_valid - v0 < 3 && c < 50) begin
      tick();
      c++;
    end
    chk("mid_reset_reach", c < 50, 1);
    do_reset();
    mark();
    load(2, 3, 8'h70, 0);
    load(0, 3, 8'h80, 0);
    run_until_idle(200);
    chk("post_reset_first", (grants.size() > 0) ? grants[0] : -1, 0);

    // Back-to-back packets from requester 2 only
    mark();
    for (int p = 0; p < 3; p++) begin
      c = 0;
      while (src[2].size() != 0 && c < 200) begin
        tick();
        c++;
      end
      chk("b2b_wait", c < 200, 1);
      tick();
      load(2, $urandom_range(2, 10), 8'h00, 1);
    end
    run_until_idle(300);
    chk("b2b_frames", n_frames - f0, 3);

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (was_empty[i] && src[i].size() == 0 && $urandom_range(0, 7) == 0) begin
          len = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 16);
          load(i, len, 8'h00, 1);
        end
      end
    end
    out_ready = 1'b1;
    run_until_idle(3000);

    chk("trunc_total", n_err, exp_trunc);
    for (int i = 0; i < N; i++) chk("leftover", exp_q[i].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
